// File: rtl/phy_pkg.sv
// Shared types and constants for the OFDM PHY frame scheduler.
//   state_t : scheduler FSM states
//   mode_t  : modulation mode, QPSK = 0, QAM = 1
//   QAM_BITS / QPSK_BITS : default frame lengths in bits
package phy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECONF  = 3'd1,
        SETTLE  = 3'd2,
        LAUNCH  = 3'd3,
        TX      = 3'd4,
        WAIT_RX = 3'd5
    } state_t;

    typedef enum logic {
        MODE_QPSK = 1'b0,
        MODE_QAM  = 1'b1
    } mode_t;

    localparam int QAM_BITS  = 384;
    localparam int QPSK_BITS = 192;

endpackage

// File: rtl/snr_qualifier.sv
// Debounces the board SNR request lines into a pending modulation mode.
//   CLK_I, RST_I   : clock, synchronous active-high reset
//   highSNR        : requests QAM
//   lowSNR         : requests QPSK
//   pending        : last request that held for STABLE_CYC consecutive cycles
module snr_qualifier
    import phy_pkg::*;
#(
    parameter int STABLE_CYC = 16
) (
    input  logic  CLK_I,
    input  logic  RST_I,
    input  logic  highSNR,
    input  logic  lowSNR,
    output mode_t pending
);

    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;

    logic          req_vld;
    mode_t         req_mode;
    logic          prev_vld;
    mode_t         prev_mode;
    logic          same;
    logic [CW-1:0] stab_cnt;

    // Exactly one line asserted is a request; both or neither is none.
    assign req_vld  = highSNR ^ lowSNR;
    assign req_mode = highSNR ? MODE_QAM : MODE_QPSK;
    assign same     = req_vld && prev_vld && (req_mode == prev_mode);

    // stab_cnt holds (run length - 1) of the current request. The update
    // fires on the edge where it reaches STABLE_CYC-1, i.e. at the end of
    // the STABLE_CYC-th consecutive cycle of the same request.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            prev_vld  <= 1'b0;
            prev_mode <= MODE_QPSK;
            stab_cnt  <= '0;
            pending   <= MODE_QPSK;
        end else begin
            prev_vld  <= req_vld;
            prev_mode <= req_mode;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != CW'(STABLE_CYC - 1))
                stab_cnt <= stab_cnt + 1'b1;
            if (same && stab_cnt == CW'(STABLE_CYC - 2))
                pending <= req_mode;
        end
    end

endmodule

// File: rtl/phy_mode_scheduler.sv
// Frame-level controller for the reconfigurable OFDM PHY. Switches the
// modulation mode only between frames, pulses start to the data generator,
// counts TX beats against the frame length and waits for the receiver to
// close the frame, aborting on timeout.
//   CLK_I, RST_I : clock, synchronous active-high reset
//   highSNR/lowSNR : mode requests (QAM / QPSK)
//   start_req    : level, frame wanted (sampled only in IDLE)
//   tx_ack       : one pulse per bit accepted by the data generator
//   rx_cyc       : receiver CYC_O, 1->0 closes the frame
//   QAM/QPSK     : complementary mode selects
//   start        : one-cycle frame start pulse
//   frm_bits     : current frame length in bits
//   busy         : high outside IDLE
//   mode_chg     : one-cycle pulse when the mode switches
//   frame_cnt    : completed frames, wrapping
//   err_timeout  : sticky abort flag
module phy_mode_scheduler #(
    parameter int STABLE_CYC  = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int QAM_BITS    = phy_pkg::QAM_BITS,
    parameter int QPSK_BITS   = phy_pkg::QPSK_BITS
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        highSNR,
    input  logic        lowSNR,
    input  logic        start_req,
    input  logic        tx_ack,
    input  logic        rx_cyc,
    output logic        QAM,
    output logic        QPSK,
    output logic        start,
    output logic [9:0]  frm_bits,
    output logic        busy,
    output logic        mode_chg,
    output logic [15:0] frame_cnt,
    output logic        err_timeout
);

    import phy_pkg::*;

    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t        state_q, state_d;
    mode_t         pending;
    mode_t         mode_q;
    logic [9:0]    bits_q;
    logic [SW-1:0] settle_cnt;
    logic [9:0]    beat_cnt;
    logic [12:0]   tmo_cnt;
    logic          rx_q;
    logic [15:0]   frame_cnt_q;
    logic          err_q;
    logic          in_frame;
    logic          tmo_exp;
    logic          rx_fall;
    logic          last_beat;

    snr_qualifier #(
        .STABLE_CYC (STABLE_CYC)
    ) u_snr (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .highSNR (highSNR),
        .lowSNR  (lowSNR),
        .pending (pending)
    );

    assign in_frame  = (state_q == TX) || (state_q == WAIT_RX);
    assign tmo_exp   = in_frame && (tmo_cnt == 13'(TIMEOUT_CYC - 1));
    // rx_q only captures rx_cyc while in WAIT_RX, so the receiver must be
    // seen high for a full WAIT_RX cycle before its fall closes the frame.
    assign rx_fall   = (state_q == WAIT_RX) && rx_q && !rx_cyc;
    assign last_beat = tx_ack && (beat_cnt == bits_q - 10'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = (pending != mode_q) ? RECONF : LAUNCH;
            RECONF:  state_d = SETTLE;
            SETTLE:  if (settle_cnt == SW'(SETTLE_CYC - 1)) state_d = LAUNCH;
            LAUNCH:  state_d = TX;
            TX:      if (tmo_exp) state_d = IDLE;
                     else if (last_beat) state_d = WAIT_RX;
            WAIT_RX: if (rx_fall || tmo_exp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            mode_q      <= MODE_QPSK;
            bits_q      <= 10'(QPSK_BITS);
            settle_cnt  <= '0;
            beat_cnt    <= '0;
            tmo_cnt     <= '0;
            rx_q        <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= (state_q == WAIT_RX) && rx_cyc;
            case (state_q)
                RECONF: begin
                    mode_q     <= pending;
                    bits_q     <= (pending == MODE_QAM) ? 10'(QAM_BITS) : 10'(QPSK_BITS);
                    settle_cnt <= '0;
                end
                SETTLE:  settle_cnt <= settle_cnt + 1'b1;
                LAUNCH: begin
                    beat_cnt <= '0;
                    tmo_cnt  <= '0;
                end
                TX: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tx_ack) beat_cnt <= beat_cnt + 1'b1;
                end
                WAIT_RX: tmo_cnt <= tmo_cnt + 1'b1;
                default: ;
            endcase
            // Completion takes priority over a coincident timeout.
            if (rx_fall)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            else if (tmo_exp)
                err_q <= 1'b1;
        end
    end

    assign QAM         = (mode_q == MODE_QAM);
    assign QPSK        = ~QAM;
    assign frm_bits    = bits_q;
    assign start       = (state_q == LAUNCH);
    assign busy        = (state_q != IDLE);
    assign mode_chg    = (state_q == RECONF);
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_phy_mode_scheduler.sv
module tb_phy_mode_scheduler;

    localparam int STABLE_CYC  = 16;
    localparam int SETTLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 4096;

    typedef struct { int qam; int bits; int cyc; } start_rec_t;
    typedef struct { int cnt; int err; int qam; int cyc; } end_rec_t;

    logic        CLK_I, RST_I, highSNR, lowSNR, start_req, tx_ack, rx_cyc;
    logic        QAM, QPSK, start, busy, mode_chg, err_timeout;
    logic [9:0]  frm_bits;
    logic [15:0] frame_cnt;

    phy_mode_scheduler dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .highSNR(highSNR), .lowSNR(lowSNR),
        .start_req(start_req), .tx_ack(tx_ack), .rx_cyc(rx_cyc),
        .QAM(QAM), .QPSK(QPSK), .start(start), .frm_bits(frm_bits),
        .busy(busy), .mode_chg(mode_chg), .frame_cnt(frame_cnt),
        .err_timeout(err_timeout)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    start_rec_t sq[$];
    end_rec_t   eq[$];
    int         chg_q[$];

    // reference state
    int run = 0, prev_req = -1;
    bit pend_qam = 0;
    bit cur_qam = 0;
    int exp_cnt = 0;
    int exp_err = 0;
    bit snr_rand_en = 0;

    initial begin
        CLK_I = 0;
        forever #5 CLK_I = ~CLK_I;
    end

    initial forever begin
        @(posedge CLK_I);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d required below limit", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int raw_req(input logic h, input logic l);
        if (h && !l) return 1;
        if (l && !h) return 0;
        return -1;
    endfunction

    // Pending mode: the last request present for STABLE_CYC cycles in a row.
    initial forever begin
        int r;
        @(posedge CLK_I);
        r = raw_req(highSNR, lowSNR);
        if (RST_I) begin
            run = 0; prev_req = -1; pend_qam = 0;
        end else begin
            if (r < 0) run = 0;
            else if (r == prev_req) run = run + 1;
            else run = 1;
            if (r >= 0 && run >= STABLE_CYC) pend_qam = (r == 1);
            prev_req = r;
        end
    end

    // Random SNR wander, active only in the random phase.
    initial begin
        int hold = 0;
        forever begin
            @(negedge CLK_I);
            if (snr_rand_en) begin
                if (hold == 0) begin
                    int c;
                    c = $urandom_range(0, 3);
                    highSNR = c[0];
                    lowSNR  = c[1];
                    hold = $urandom_range(1, 40);
                end else hold--;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents start, mode_chg or
    // the end of a frame (busy falling).
    initial begin
        start_rec_t s;
        end_rec_t   e;
        bit busy_prev = 0;
        forever begin
            @(negedge CLK_I);
            check("qpsk_complement", QPSK, !QAM);
            if (start) begin
                check("start_expected", sq.size() > 0, 1);
                if (sq.size() > 0) begin
                    s = sq.pop_front();
                    check("start_cycle", cyc, s.cyc);
                    check("start_qam", QAM, s.qam);
                    check("start_frm_bits", frm_bits, s.bits);
                end
            end
            if (mode_chg) begin
                check("mode_chg_expected", chg_q.size() > 0, 1);
                if (chg_q.size() > 0) check("mode_chg_cycle", cyc, chg_q.pop_front());
            end
            if (busy_prev && !busy) begin
                check("frame_end_expected", eq.size() > 0, 1);
                if (eq.size() > 0) begin
                    e = eq.pop_front();
                    check("end_cycle", cyc, e.cyc);
                    check("end_frame_cnt", frame_cnt, e.cnt);
                    check("end_err_timeout", err_timeout, e.err);
                    check("end_qam_held", QAM, e.qam);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic check_reset_outputs();
        check("rst_QAM", QAM, 0);
        check("rst_QPSK", QPSK, 1);
        check("rst_start", start, 0);
        check("rst_frm_bits", frm_bits, 192);
        check("rst_busy", busy, 0);
        check("rst_mode_chg", mode_chg, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_timeout", err_timeout, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge CLK_I);
        while (busy && t < 6000) begin
            @(negedge CLK_I);
            t++;
        end
        if (busy) check("wait_idle_bound", busy, 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    // kind: 0 normal, 1 rx fall on the timeout expiry cycle, 2 timeout,
    //       3 reset after 100 beats
    task automatic run_frame(input bit keep, input bit early_rx, input int kind,
                             input int mid_switch);
        int k, L, got, t;
        bit chg, erx;
        start_rec_t s;
        end_rec_t   e;
        erx = early_rx;
        wait_idle();
        k = cyc;
        chg = (pend_qam != cur_qam);
        start_req = 1;
        if (chg) begin
            chg_q.push_back(k + 1);
            @(negedge CLK_I);
            cur_qam = pend_qam;
        end
        s.qam  = cur_qam;
        s.bits = cur_qam ? 384 : 192;
        s.cyc  = k + (chg ? SETTLE_CYC + 2 : 1);
        sq.push_back(s);
        t = 0;
        while (!start && t < SETTLE_CYC + 6) begin
            @(negedge CLK_I);
            t++;
        end
        if (!start) begin
            check("start_seen", start, 1);
            start_req = 0;
            return;
        end
        start_req = keep;
        L = cyc;
        got = 0;
        while (got < s.bits) begin
            @(negedge CLK_I);
            if (kind == 3 && got == 100) break;
            if (erx && got == s.bits - 1) begin
                // receiver activity before the last beat must be ignored
                tx_ack = 0; rx_cyc = 1;
                wait_cycles(2);
                rx_cyc = 0;
                wait_cycles(2);
                erx = 0;
            end
            if (mid_switch >= 0 && got == mid_switch) begin
                highSNR = 0; lowSNR = 1;
            end
            tx_ack = ($urandom_range(0, 3) != 0);
            if (tx_ack) got++;
        end
        if (kind == 3) begin
            tx_ack = 0; start_req = 0; RST_I = 1;
            e.cnt = 0; e.err = 0; e.qam = 0; e.cyc = cyc + 1;
            eq.push_back(e);
            @(negedge CLK_I);
            check_reset_outputs();
            RST_I = 0;
            cur_qam = 0; exp_cnt = 0; exp_err = 0;
            return;
        end
        @(negedge CLK_I);
        if (kind == 2) begin
            tx_ack = 0;
            e.cnt = exp_cnt; e.err = 1; e.qam = cur_qam; e.cyc = L + TIMEOUT_CYC + 1;
            eq.push_back(e);
            exp_err = 1;
            return;
        end
        rx_cyc = 1;
        tx_ack = $urandom_range(0, 1);  // surplus beats after the frame is full
        if (kind == 1) begin
            while (cyc < L + TIMEOUT_CYC) @(negedge CLK_I);
        end else begin
            wait_cycles($urandom_range(1, 3));
        end
        rx_cyc = 0; tx_ack = 0;
        exp_cnt = (exp_cnt + 1) % 65536;
        e.cnt = exp_cnt; e.err = exp_err; e.qam = cur_qam; e.cyc = cyc + 1;
        eq.push_back(e);
    endtask

    initial begin
        RST_I = 1; highSNR = 0; lowSNR = 0; start_req = 0; tx_ack = 0; rx_cyc = 0;
        wait_cycles(3);
        check_reset_outputs();
        RST_I = 0;

        // QPSK frames, start_req held: second one launches back-to-back
        lowSNR = 1;
        run_frame(1, 0, 0, -1);
        run_frame(0, 0, 0, -1);

        // QAM request one cycle short of qualification: no change
        lowSNR = 0; highSNR = 1;
        wait_cycles(STABLE_CYC - 1);
        highSNR = 0;
        wait_cycles(4);
        run_frame(0, 0, 0, -1);

        // both lines asserted: no request
        highSNR = 1; lowSNR = 1;
        wait_cycles(STABLE_CYC + 4);
        highSNR = 0; lowSNR = 0;
        run_frame(0, 0, 0, -1);

        // qualified QAM: reconfigure, early rx activity ignored
        highSNR = 1;
        wait_cycles(STABLE_CYC);
        run_frame(0, 1, 0, -1);
        // switch to QPSK mid-frame: held until the next frame
        run_frame(0, 0, 0, 60);
        run_frame(0, 0, 0, -1);

        // randomized SNR wander and frame options
        snr_rand_en = 1;
        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(0, 1), $urandom_range(0, 1), 0, -1);
        snr_rand_en = 0;
        highSNR = 0; lowSNR = 1;

        // rx fall on the expiry cycle wins, then a real timeout, then sticky
        run_frame(0, 0, 1, -1);
        run_frame(0, 0, 2, -1);
        run_frame(0, 0, 0, -1);

        // reset during TX
        run_frame(0, 0, 3, -1);

        // frame counter wrap
        wait_idle();
        dut.frame_cnt_q = 16'hFFFF;
        exp_cnt = 65535;
        run_frame(0, 0, 0, -1);

        wait_idle();
        wait_cycles(5);
        check("start_queue_drained", sq.size(), 0);
        check("end_queue_drained", eq.size(), 0);
        check("mode_chg_queue_drained", chg_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
